vip_featuremap_conv2d_1_filter: RTL and testbench



---
 rtl/vip_featuremap_conv2d_1_filter.sv | 181 ++++++++++++++++++
 tb/tb_vip_featuremap_conv2d_1_filter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vip_featuremap_conv2d_1_filter.sv
// rtl/vip_featuremap_conv2d_1_filter.sv - pointwise 1x1 conv for one conv2d_1 filter with output FIFO
// Optional ReLU on the saturated result: define VIP_CONV2D_1_RELU_EN.
module vip_featuremap_conv2d_1_filter #(
    parameter int                        DWIDTH     = 32,
    parameter int                        FRAC       = 16,
    parameter logic signed [DWIDTH-1:0]  W0         = 32'h0001_0000,
    parameter logic signed [DWIDTH-1:0]  W1         = 32'h0001_0000,
    parameter logic signed [DWIDTH-1:0]  W2         = 32'h0001_0000,
    parameter logic signed [DWIDTH-1:0]  W3         = 32'h0001_0000,
    parameter logic signed [DWIDTH-1:0]  W4         = 32'h0001_0000,
    parameter logic signed [DWIDTH-1:0]  W5         = 32'h0001_0000,
    parameter logic signed [DWIDTH-1:0]  W6         = 32'h0001_0000,
    parameter logic signed [DWIDTH-1:0]  W7         = 32'h0001_0000,
    parameter logic signed [DWIDTH-1:0]  BIAS       = 32'h0000_0000,
    parameter int                        FIFO_DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DWIDTH-1:0] fifo_in_data0,
    input  logic [DWIDTH-1:0] fifo_in_data1,
    input  logic [DWIDTH-1:0] fifo_in_data2,
    input  logic [DWIDTH-1:0] fifo_in_data3,
    input  logic [DWIDTH-1:0] fifo_in_data4,
    input  logic [DWIDTH-1:0] fifo_in_data5,
    input  logic [DWIDTH-1:0] fifo_in_data6,
    input  logic [DWIDTH-1:0] fifo_in_data7,
    input  logic              fifo_in_wrreq,
    output logic              fifo_in_full,
    output logic [DWIDTH-1:0] fifo_out_data,
    input  logic              fifo_out_rdreq,
    output logic              fifo_out_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = 2 * DWIDTH;
    localparam int SW = PW + 4;

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    function automatic logic signed [DWIDTH-1:0] weight(input int i);
        case (i)
            0:       return W0;
            1:       return W1;
            2:       return W2;
            3:       return W3;
            4:       return W4;
            5:       return W5;
            6:       return W6;
            default: return W7;
        endcase
    endfunction

    // Full-width signed product, then floor-rounded back to the data's binary point.
    function automatic logic signed [PW-1:0] mul_shift(input logic signed [DWIDTH-1:0] d,
                                                       input logic signed [DWIDTH-1:0] w);
        logic signed [PW-1:0] de;
        logic signed [PW-1:0] we;
        de = d;
        we = w;
        return (de * we) >>> FRAC;
    endfunction

    logic [DWIDTH-1:0]        din [8];
    logic signed [DWIDTH-1:0] s0_d [8];
    logic                     s0_v;
    logic signed [PW-1:0]     s1_p [8];
    logic                     s1_v;
    logic [DWIDTH-1:0]        s2_r;
    logic                     s2_v;
    logic                     accept;

    logic signed [SW-1:0]     acc;
    logic [DWIDTH-1:0]        sat;
    logic [DWIDTH-1:0]        res;

    logic [DWIDTH-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              count;
    logic                     push;
    logic                     pop;
    logic [AW+1:0]            occupancy;

    assign din[0] = fifo_in_data0;
    assign din[1] = fifo_in_data1;
    assign din[2] = fifo_in_data2;
    assign din[3] = fifo_in_data3;
    assign din[4] = fifo_in_data4;
    assign din[5] = fifo_in_data5;
    assign din[6] = fifo_in_data6;
    assign din[7] = fifo_in_data7;

    assign accept = fifo_in_wrreq && !fifo_in_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0_v <= 1'b0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s0_v <= accept;
            s1_v <= s0_v;
            s2_v <= s1_v;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            for (int i = 0; i < 8; i++) begin
                s0_d[i] <= $signed(din[i]);
            end
        end
        if (s0_v) begin
            for (int i = 0; i < 8; i++) begin
                s1_p[i] <= mul_shift(s0_d[i], weight(i));
            end
        end
        if (s1_v) begin
            s2_r <= res;
        end
    end

    always_comb begin
        acc = BIAS;
        for (int i = 0; i < 8; i++) begin
            acc = acc + s1_p[i];
        end
        if (acc > SAT_MAX) begin
            sat = SAT_MAX[DWIDTH-1:0];
        end else if (acc < SAT_MIN) begin
            sat = SAT_MIN[DWIDTH-1:0];
        end else begin
            sat = acc[DWIDTH-1:0];
        end
`ifdef VIP_CONV2D_1_RELU_EN
        res = sat[DWIDTH-1] ? '0 : sat;
`else
        res = sat;
`endif
    end

    // Output FIFO: the full flag counts in-flight stages so a result always has a slot.
    assign push = s2_v;
    assign pop  = fifo_out_rdreq && (count != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= s2_r;
        end
    end

    always_comb begin
        occupancy = (AW+2)'(count) + (AW+2)'(s0_v) + (AW+2)'(s1_v) + (AW+2)'(s2_v);
    end

    assign fifo_in_full   = occupancy >= (AW+2)'(FIFO_DEPTH);
    assign fifo_out_empty = (count == '0);
    assign fifo_out_data  = fifo_out_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_vip_featuremap_conv2d_1_filter.sv
// tb/tb_vip_featuremap_conv2d_1_filter.sv - directed vector bench for vip_featuremap_conv2d_1_filter
module tb_vip_featuremap_conv2d_1_filter;

`ifdef VIP_CONV2D_1_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [7:0][31:0]  din;
    logic              wrreq;
    logic              rdreq;
    logic              fifo_in_full;
    logic [31:0]       fifo_out_data;
    logic              fifo_out_empty;

    int total  = 0;
    int passed = 0;

    logic [31:0] expq [$];

    typedef struct {
        string            name;
        logic [7:0][31:0] d;
        logic [31:0]      res;
    } vec_t;

    vec_t vecs [7];

    vip_featuremap_conv2d_1_filter dut (
        .clock          (clock),
        .reset          (reset),
        .fifo_in_data0  (din[0]),
        .fifo_in_data1  (din[1]),
        .fifo_in_data2  (din[2]),
        .fifo_in_data3  (din[3]),
        .fifo_in_data4  (din[4]),
        .fifo_in_data5  (din[5]),
        .fifo_in_data6  (din[6]),
        .fifo_in_data7  (din[7]),
        .fifo_in_wrreq  (wrreq),
        .fifo_in_full   (fifo_in_full),
        .fifo_out_data  (fifo_out_data),
        .fifo_out_rdreq (rdreq),
        .fifo_out_empty (fifo_out_empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Pushes one pixel and watches the result arrive exactly three edges later.
    task automatic run_vec(input vec_t v);
        @(negedge clock);
        din   = v.d;
        wrreq = 1'b1;
        @(negedge clock);
        wrreq = 1'b0;
        din   = '0;
        check({v.name, " empty after N"}, 32'(fifo_out_empty), 32'd1);
        @(negedge clock);
        check({v.name, " empty after N+1"}, 32'(fifo_out_empty), 32'd1);
        @(negedge clock);
        check({v.name, " empty after N+2"}, 32'(fifo_out_empty), 32'd1);
        @(negedge clock);
        check({v.name, " empty after N+3"}, 32'(fifo_out_empty), 32'd0);
        check({v.name, " data"}, fifo_out_data, v.res);
        rdreq = 1'b1;
        @(negedge clock);
        rdreq = 1'b0;
        check({v.name, " empty after pop"}, 32'(fifo_out_empty), 32'd1);
    endtask

    // Called at a negedge with the pipeline idle; pops until empty (bounded).
    task automatic drain_all(input string name, input int expect_n);
        int          got;
        logic [31:0] req;
        got = 0;
        for (int i = 0; i < 32; i++) begin
            if (fifo_out_empty) break;
            req = (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_BEEF;
            check($sformatf("%s entry %0d", name, got), fifo_out_data, req);
            rdreq = 1'b1;
            @(negedge clock);
            rdreq = 1'b0;
            got++;
        end
        check({name, " drained count"}, 32'(got), 32'(expect_n));
        check({name, " empty at end"}, 32'(fifo_out_empty), 32'd1);
        expq.delete();
    endtask

    initial begin
        logic [31:0] val;
        int          acc_n;
        bit          stayed_full;
        bit          stayed_low;

        vecs[0] = '{"unity",   {8{32'h0001_0000}}, 32'h0008_0000};
        vecs[1] = '{"neg_one", {8{32'hFFFF_0000}}, RELU ? 32'h0 : 32'hFFF8_0000};
        vecs[2] = '{"sat_pos", {8{32'h7FFF_FFFF}}, 32'h7FFF_FFFF};
        vecs[3] = '{"sat_neg", {8{32'h8000_0000}}, RELU ? 32'h0 : 32'h8000_0000};
        // listed channel 7 down to channel 0: 3 - lsb + lsb + 0.25 + 0 - 0.5 + 2 + 1 = 5.75
        vecs[4] = '{"mixed", {32'h0003_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_4000,
                              32'h0000_0000, 32'hFFFF_8000, 32'h0002_0000, 32'h0001_0000},
                    32'h0005_C000};
        vecs[5] = '{"minus_lsb", {224'h0, 32'hFFFF_FFFF}, RELU ? 32'h0 : 32'hFFFF_FFFF};
        vecs[6] = '{"neg16", {192'h0, 32'hFFE0_0000, 32'h0010_0000}, RELU ? 32'h0 : 32'hFFF0_0000};

        din   = '0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        #12;
        check("reset empty", 32'(fifo_out_empty), 32'd1);
        check("reset full", 32'(fifo_in_full), 32'd0);
        check("reset data", fifo_out_data, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: 20 cycles of wrreq, no reads.
        acc_n       = 0;
        stayed_full = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (!fifo_in_full) begin
                acc_n++;
                expq.push_back(32'((c + 1) << 19));
            end else if (c < 16) begin
                stayed_full = stayed_full;
            end
            if (c >= 16 && !fifo_in_full) stayed_full = 1'b0;
            val   = 32'((c + 1) << 16);
            din   = {8{val}};
            wrreq = 1'b1;
        end
        @(negedge clock);
        if (!fifo_in_full) stayed_full = 1'b0;
        wrreq = 1'b0;
        check("bp accepted", 32'(acc_n), 32'd16);
        check("bp full held", 32'(stayed_full), 32'd1);
        repeat (3) @(negedge clock);
        check("bp full before drain", 32'(fifo_in_full), 32'd1);
        drain_all("bp", 16);
        check("bp full after drain", 32'(fifo_in_full), 32'd0);

        // Concurrent push/pop with 8 queued.
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            val   = 32'((c + 1) << 16);
            din   = {8{val}};
            wrreq = 1'b1;
            expq.push_back(32'((c + 1) << 19));
        end
        @(negedge clock);
        wrreq = 1'b0;
        repeat (3) @(negedge clock);
        stayed_low = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clock);
            if (fifo_in_full) stayed_low = 1'b0;
            val = (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_BEEF;
            check($sformatf("rw head %0d", c), fifo_out_data, val);
            rdreq = 1'b1;
            if (!fifo_in_full) begin
                val   = 32'((c + 9) << 16);
                din   = {8{val}};
                wrreq = 1'b1;
                expq.push_back(32'((c + 9) << 19));
            end else begin
                wrreq = 1'b0;
            end
        end
        @(negedge clock);
        if (fifo_in_full) stayed_low = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        check("rw full low", 32'(stayed_low), 32'd1);
        repeat (3) @(negedge clock);
        drain_all("rw", 8);

        // Reset with 5 queued and 3 in flight.
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            val   = 32'((c + 1) << 16);
            din   = {8{val}};
            wrreq = 1'b1;
        end
        @(negedge clock);
        wrreq = 1'b0;
        check("pre-reset empty", 32'(fifo_out_empty), 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("mid reset empty", 32'(fifo_out_empty), 32'd1);
        check("mid reset full", 32'(fifo_in_full), 32'd0);
        check("mid reset data", fifo_out_data, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("post reset no stale", 32'(fifo_out_empty), 32'd1);
        run_vec(vecs[4]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
